mem_burst_responder: RTL
========================

MEM_BURST_RESPONDER -- requirements
Module: mem_burst_responder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, which sets the word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, which sets the byte address width.
REQ-003 The block SHALL have parameter WORDS_PER_LINE, default 4 (power of two), which sets the beats per burst.
REQ-004 The block SHALL have parameter LATENCY, default 2, which sets the access wait in cycles (0 allowed).
REQ-005 The block SHALL have parameter DEPTH_WORDS, default 1024, which sets the storage size in words.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have ports req_valid (in, 1), req_ready (out, 1), req_write (in, 1; 1 = writeback, 0 = refill) and req_addr (in, ADDR_WIDTH): the line request handshake.
REQ-009 The block SHALL have ports rvalid (out, 1), rready (in, 1), rdata (out, DATA_WIDTH) and rlast (out, 1): the refill beat channel.
REQ-010 The block SHALL have ports wvalid (in, 1), wready (out, 1) and wdata (in, DATA_WIDTH): the writeback beat channel.
REQ-011 The block SHALL have port wdone, out, 1 bit: a one-cycle pulse when a writeback completes.
REQ-012 The block SHALL have port busy, out, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 The block SHALL implement the states IDLE, WAIT, RBURST, WBURST and WDONE.
REQ-014 req_ready SHALL be high only in IDLE, and a request SHALL be accepted when req_valid and req_ready are both high.
REQ-015 On acceptance, the block SHALL latch the line base word index as req_addr divided by (DATA_WIDTH/8), with its low log2(WORDS_PER_LINE) bits forced to 0, modulo DEPTH_WORDS.
REQ-016 On acceptance, the block SHALL latch req_write, clear the beat counter and load the wait counter with LATENCY.
REQ-017 On acceptance with LATENCY=0, the block SHALL go directly to RBURST or WBURST; otherwise it SHALL enter WAIT.
REQ-018 WAIT SHALL last exactly LATENCY cycles, then go to RBURST if req_write=0 or to WBURST if req_write=1.
REQ-019 In RBURST, rvalid SHALL be 1 and rdata SHALL equal mem[base + beat].
REQ-020 In RBURST, rlast SHALL be 1 when beat = WORDS_PER_LINE-1.
REQ-021 In RBURST, the beat SHALL advance only on rvalid&&rready, and rdata SHALL be held stable while rready=0.
REQ-022 The final read handshake SHALL return the block to IDLE, so the next request can be accepted on the following cycle.
REQ-023 In WBURST, wready SHALL be 1, and each wvalid&&wready SHALL write wdata to mem[base + beat] and advance the beat.
REQ-024 The final write beat SHALL move the block to WDONE, which asserts wdone for exactly one cycle and then returns to IDLE.
REQ-025 The beat index SHALL wrap within the line: base + beat never crosses a line boundary, and no beat beyond WORDS_PER_LINE is ever issued.
REQ-026 rvalid, rlast and rdata SHALL be 0 outside RBURST; wready SHALL be 0 outside WBURST.
REQ-027 wvalid outside WBURST SHALL be ignored, with no memory write.
REQ-028 req_valid outside IDLE SHALL be ignored; the requester holds the request until it is accepted.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, clear the beat and wait counters, and drive req_ready=1 and all other outputs to 0.
REQ-030 Reset mid-burst SHALL abort the burst: no further memory writes, and any already-written beats remain.
REQ-031 Memory array contents SHALL NOT be affected by reset.

Configuration
REQ-032 With MEM_WSTRB_EN defined, the block SHALL add input wstrb of width DATA_WIDTH/8, and each write beat SHALL update only the bytes whose strobe bit is 1, leaving the other bytes unchanged.
REQ-033 With MEM_WSTRB_EN undefined, the block SHALL have no wstrb port, and every write beat SHALL update the full word.

Verification
REQ-034 Refill with mem[4..7]=11,22,33,44, req_addr=0x14, LATENCY=2, rready=1 -> req accepted in cycle 0, rvalid first in cycle 3, rdata 11,22,33,44 in consecutive cycles, rlast on 44, busy drops in cycle 7.
REQ-035 Refill with rready toggling 1,0,0,1,... -> rdata held stable while rready=0, no beat skipped or repeated, rlast exactly once.
REQ-036 Writeback to req_addr=0x20 with beats A,B,C,D and wvalid gaps -> mem[8..11]=A,B,C,D, wdone single pulse after D, then back in IDLE.
REQ-037 rst asserted after beat 2 of a writeback -> outputs zero immediately, req_ready=1, mem[8..9] updated and mem[10..11] unchanged.
REQ-038 MEM_WSTRB_EN, mem[0]=0x11223344, write 0xAABBCCDD with wstrb=0b0101 -> mem[0]=0x11BB33DD; LATENCY=0 refill -> rvalid in the cycle after acceptance.

Source files
------------

// File: rtl/mem_burst_responder_if.sv
// Line request, refill beat and writeback beat channels of mem_burst_responder.
// wstrb is present only when MEM_WSTRB_EN is defined.
interface mem_burst_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rlast;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
`ifdef MEM_WSTRB_EN
  logic [DATA_WIDTH/8-1:0] wstrb;
`endif
  logic                  wdone;
  logic                  busy;

`ifdef MEM_WSTRB_EN
  modport master (
    output req_valid, req_write, req_addr, rready, wvalid, wdata, wstrb,
    input  req_ready, rvalid, rdata, rlast, wready, wdone, busy
  );
  modport slave (
    input  req_valid, req_write, req_addr, rready, wvalid, wdata, wstrb,
    output req_ready, rvalid, rdata, rlast, wready, wdone, busy
  );
`else
  modport master (
    output req_valid, req_write, req_addr, rready, wvalid, wdata,
    input  req_ready, rvalid, rdata, rlast, wready, wdone, busy
  );
  modport slave (
    input  req_valid, req_write, req_addr, rready, wvalid, wdata,
    output req_ready, rvalid, rdata, rlast, wready, wdone, busy
  );
`endif
endinterface

// File: rtl/mem_burst_responder.sv
// Line-burst memory model: refills and writebacks of WORDS_PER_LINE words; MEM_WSTRB_EN adds byte strobes.
// Latency: LATENCY wait cycles after acceptance, then one beat per handshake; wdone one cycle after last write.
// Backpressure: beats advance only on rvalid&&rready / wvalid&&wready; req_ready only while idle.
module mem_burst_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int LATENCY        = 2,
  parameter int DEPTH_WORDS    = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_burst_responder_if.slave   bus
);
  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int BEAT_W     = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int WAIT_W     = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(LATENCY);

  typedef enum logic [2:0] {IDLE, WAIT, RBURST, WBURST, WDONE} state_t;

  state_t             state, state_d;
  logic [BEAT_W-1:0]  beat, beat_d;
  logic [WAIT_W-1:0]  wait_cnt, wait_d;
  logic [IDX_W-1:0]   base, base_d;
  logic               is_write, write_d;
  logic [ADDR_WIDTH-1:0] word_addr, line_addr;
  logic [IDX_W-1:0]   base_in, mem_idx;
  logic               wr_fire;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // Base word of the addressed line, folded into the storage range.
  always_comb begin
    word_addr = bus.req_addr >> BYTE_SHIFT;
    line_addr = word_addr & ~ADDR_WIDTH'(WORDS_PER_LINE - 1);
    base_in   = IDX_W'(line_addr % ADDR_WIDTH'(DEPTH_WORDS));
  end

  assign mem_idx = base + IDX_W'(beat);
  assign wr_fire = (state == WBURST) && bus.wvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat     <= '0;
      wait_cnt <= '0;
      base     <= '0;
      is_write <= 1'b0;
    end else begin
      state    <= state_d;
      beat     <= beat_d;
      wait_cnt <= wait_d;
      base     <= base_d;
      is_write <= write_d;
    end
  end

  // Storage has no reset; an aborted burst keeps the beats already written.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
`ifdef MEM_WSTRB_EN
      for (int b = 0; b < BYTES; b++) begin
        if (bus.wstrb[b]) mem[mem_idx][b*8 +: 8] <= bus.wdata[b*8 +: 8];
      end
`else
      mem[mem_idx] <= bus.wdata;
`endif
    end
  end

  always_comb begin
    state_d       = state;
    beat_d        = beat;
    wait_d        = wait_cnt;
    base_d        = base;
    write_d       = is_write;
    bus.req_ready = 1'b0;
    bus.rvalid    = 1'b0;
    bus.rdata     = '0;
    bus.rlast     = 1'b0;
    bus.wready    = 1'b0;
    bus.wdone     = 1'b0;
    bus.busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          base_d  = base_in;
          write_d = bus.req_write;
          beat_d  = '0;
          wait_d  = WAIT_LOAD;
          if (LATENCY == 0) state_d = bus.req_write ? WBURST : RBURST;
          else              state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt <= WAIT_W'(1)) begin
          wait_d  = '0;
          state_d = is_write ? WBURST : RBURST;
        end else begin
          wait_d = wait_cnt - WAIT_W'(1);
        end
      end
      RBURST: begin
        bus.rvalid = 1'b1;
        bus.rdata  = mem[mem_idx];
        bus.rlast  = (beat == LAST_BEAT);
        if (bus.rready) begin
          beat_d  = (beat == LAST_BEAT) ? '0 : beat + BEAT_W'(1);
          if (beat == LAST_BEAT) state_d = IDLE;
        end
      end
      WBURST: begin
        bus.wready = 1'b1;
        if (bus.wvalid) begin
          beat_d = (beat == LAST_BEAT) ? '0 : beat + BEAT_W'(1);
          if (beat == LAST_BEAT) state_d = WDONE;
        end
      end
      WDONE: begin
        bus.wdone = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
